sec_tick_counter: RTL and testbench
===================================

Name: sec_tick_counter

Overview:
- Consumes the slow toggling 1 s timebase produced by the clock divider, on the far end of that square-wave interface.
- Synchronises the input, detects rising edges (one per second) and keeps a BCD MM:SS stopwatch with start/stop/clear control.
- Sits between the timebase and the 7-segment display driver; all logic runs on the fast system clock.

Parameters:
SYNC_STAGES, 2, number of flops in the tick_in synchroniser (legal range 2..4)
WRAP, 1, 1 = roll 59:59 -> 00:00; 0 = saturate at 59:59 and pause

Ports:
clk  input  1  system clock (fast, e.g. 50 MHz)
rst  input  1  synchronous, active-high reset
tick_in  input  1  toggling timebase; one rising edge per second; asynchronous to clk
start  input  1  single-cycle pulse: begin/resume counting
stop  input  1  single-cycle pulse: pause counting
clear  input  1  single-cycle pulse: zero time, go idle
sec_lo  output  4  BCD seconds units, 0..9
sec_hi  output  4  BCD seconds tens, 0..5
min_lo  output  4  BCD minutes units, 0..9
min_hi  output  4  BCD minutes tens, 0..5
running  output  1  high while in RUN
sec_pulse  output  1  one-cycle pulse on every applied increment
ovf  output  1  one-cycle pulse on 59:59 rollover or saturation attempt

Behaviour:
- Reset (sync, rst high at a clk edge): all digits 0, running 0, sec_pulse 0, ovf 0, all synchroniser flops and the edge flop 0, state IDLE.
- Synchroniser: SYNC_STAGES flops in series, then one edge flop. rise = sync_out & ~edge_q.
- Latency: if tick_in is first sampled high at edge N, rise is high during the cycle after edge N+SYNC_STAGES-1. The digits and sec_pulse update at edge N+SYNC_STAGES (edge N+2 for the default).
- Any tick_in high pulse shorter than one clk period may be missed; no requirement is placed on it.
- States:
  - IDLE: time is 00:00, not counting.
  - RUN: counting.
  - PAUSE: holding the current time.
- Transitions, in priority order rst > clear > stop > start:
  - clear: any state -> IDLE; digits zeroed.
  - stop: RUN -> PAUSE; ignored in IDLE and PAUSE.
  - start: IDLE/PAUSE -> RUN; ignored in RUN.
- Increment applies only when state==RUN, rise==1, and neither clear nor stop is high in the same cycle.
  - start in the same cycle as rise: that edge is not counted.
  - stop in the same cycle as rise: that edge is not counted.
- Carry chain, all in one cycle:
  - sec_lo 9 -> 0 carries into sec_hi.
  - sec_hi 5 -> 0 carries into min_lo.
  - min_lo 9 -> 0 carries into min_hi.
  - min_hi 5 with all lower digits at max is the 59:59 boundary.
- At 59:59 plus an increment:
  - WRAP=1: -> 00:00, ovf=1 for one cycle, sec_pulse=1, stays in RUN.
  - WRAP=0: digits hold at 59:59, ovf=1 for one cycle, sec_pulse=0, state -> PAUSE; a later start re-enters RUN, and the next edge pulses ovf again.
- running is registered and equals (state==RUN); it changes on the same edge as the state.
- tick_in already high at reset release produces one rise. It is harmless because the block is in IDLE.
- Reset mid-count: the time is lost; there is no retention.

Optional Feature:
- Macro: SEC_TICK_COUNTER_ALARM_EN
- Defined:
  - Adds input alarm_time (16 bits, BCD {min_hi,min_lo,sec_hi,sec_lo}) and output alarm (1 bit, registered, reset 0).
  - alarm sets on the edge where an increment makes the displayed time equal alarm_time.
  - alarm stays high until clear or start; rst also clears it.
  - An alarm_time of 00:00 never fires from a clear.
- Undefined: neither port exists and there is no comparator logic.

Test Plan:
- rst, start, then 5 tick_in rising edges spaced 100 clk apart -> digits read 00:05. Each sec_pulse arrives exactly 2 clk after tick_in is sampled high. running=1 throughout.
- Preload to 00:58 via ticks, then 2 edges -> 00:59, then 01:00. Run on to 59:59; with WRAP=1 the next edge gives 00:00, ovf one cycle, running still 1.
- WRAP=0 at 59:59, one edge -> digits stay 59:59, ovf pulses once, sec_pulse=0, running -> 0. start plus one edge -> ovf pulses again.
- stop asserted in the same cycle as rise at 00:07 -> stays 00:07, running 0. Further edges are ignored. start then one edge -> 00:08.
- clear and start both high in the same cycle as rise at 03:21 -> 00:00, state IDLE, no sec_pulse.
- ALARM_EN, alarm_time=16'h0003: 3 edges -> alarm=1 on the edge reaching 00:03 and still 1 after 00:04. clear -> alarm=0.

Source files
------------

// File: rtl/sec_tick_counter.sv
// BCD MM:SS stopwatch driven by a synchronised 1 s toggling timebase.
// Optional alarm comparator is compiled in when SEC_TICK_COUNTER_ALARM_EN is defined.
`timescale 1ns/1ps

module sec_tick_counter #(
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       sec_pulse,
  output logic       ovf
`ifdef SEC_TICK_COUNTER_ALARM_EN
  ,
  input  logic [15:0] alarm_time,
  output logic        alarm
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   sync_out;
  logic                   rise;
  logic [3:0]             nxt_sec_lo;
  logic [3:0]             nxt_sec_hi;
  logic [3:0]             nxt_min_lo;
  logic [3:0]             nxt_min_hi;
  logic                   at_max;
  logic                   inc_req;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~edge_q;

  // tick_in is asynchronous to clk; the edge flop sits after the last sync stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      edge_q <= sync_out;
    end
  end

  always_comb begin
    nxt_sec_lo = sec_lo + 4'd1;
    nxt_sec_hi = sec_hi;
    nxt_min_lo = min_lo;
    nxt_min_hi = min_hi;
    if (sec_lo == 4'd9) begin
      nxt_sec_lo = 4'd0;
      nxt_sec_hi = sec_hi + 4'd1;
      if (sec_hi == 4'd5) begin
        nxt_sec_hi = 4'd0;
        nxt_min_lo = min_lo + 4'd1;
        if (min_lo == 4'd9) begin
          nxt_min_lo = 4'd0;
          nxt_min_hi = (min_hi == 4'd5) ? 4'd0 : min_hi + 4'd1;
        end
      end
    end
  end

  assign at_max  = (min_hi == 4'd5) && (min_lo == 4'd9) &&
                   (sec_hi == 4'd5) && (sec_lo == 4'd9);
  // A rise coinciding with clear or stop is deliberately dropped
  assign inc_req = (state == RUN) && rise && !clear && !stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      running   <= 1'b0;
      sec_pulse <= 1'b0;
      ovf       <= 1'b0;
      sec_lo    <= 4'd0;
      sec_hi    <= 4'd0;
      min_lo    <= 4'd0;
      min_hi    <= 4'd0;
    end else begin
      sec_pulse <= 1'b0;
      ovf       <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
        sec_lo  <= 4'd0;
        sec_hi  <= 4'd0;
        min_lo  <= 4'd0;
        min_hi  <= 4'd0;
      end else if (stop) begin
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (start && (state != RUN)) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (inc_req) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (WRAP) begin
            sec_pulse <= 1'b1;
            sec_lo    <= 4'd0;
            sec_hi    <= 4'd0;
            min_lo    <= 4'd0;
            min_hi    <= 4'd0;
          end else begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end else begin
          sec_pulse <= 1'b1;
          sec_lo    <= nxt_sec_lo;
          sec_hi    <= nxt_sec_hi;
          min_lo    <= nxt_min_lo;
          min_hi    <= nxt_min_hi;
        end
      end
    end
  end

`ifdef SEC_TICK_COUNTER_ALARM_EN
  logic inc_applied;

  // Saturation leaves the display unchanged, so it can never newly match
  assign inc_applied = inc_req && (!at_max || WRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (clear) begin
      alarm <= 1'b0;
    end else if (inc_applied &&
                 ({nxt_min_hi, nxt_min_lo, nxt_sec_hi, nxt_sec_lo} == alarm_time)) begin
      alarm <= 1'b1;
    end else if (start) begin
      alarm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sec_tick_counter.sv
// Directed bench for sec_tick_counter: a wrapping and a saturating instance share stimulus.
`timescale 1ns/1ps

module tb_sec_tick_counter;

  logic clk = 1'b0;
  logic rst, tick_in, start, stop, clear;

  logic [3:0] w_sec_lo, w_sec_hi, w_min_lo, w_min_hi;
  logic       w_running, w_sec_pulse, w_ovf;
  logic [3:0] s_sec_lo, s_sec_hi, s_min_lo, s_min_hi;
  logic       s_running, s_sec_pulse, s_ovf;
`ifdef SEC_TICK_COUNTER_ALARM_EN
  logic [15:0] alarm_time;
  logic        w_alarm, s_alarm;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic        s;
    logic        p;
    logic        c;
    int          n;
    logic [15:0] t;
    logic        r;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  sec_tick_counter #(.SYNC_STAGES(2), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .sec_lo(w_sec_lo), .sec_hi(w_sec_hi), .min_lo(w_min_lo), .min_hi(w_min_hi),
    .running(w_running), .sec_pulse(w_sec_pulse), .ovf(w_ovf)
`ifdef SEC_TICK_COUNTER_ALARM_EN
    , .alarm_time(alarm_time), .alarm(w_alarm)
`endif
  );

  sec_tick_counter #(.SYNC_STAGES(2), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .sec_lo(s_sec_lo), .sec_hi(s_sec_hi), .min_lo(s_min_lo), .min_hi(s_min_hi),
    .running(s_running), .sec_pulse(s_sec_pulse), .ovf(s_ovf)
`ifdef SEC_TICK_COUNTER_ALARM_EN
    , .alarm_time(alarm_time), .alarm(s_alarm)
`endif
  );

  function automatic logic [15:0] w_time();
    return {w_min_hi, w_min_lo, w_sec_hi, w_sec_lo};
  endfunction

  function automatic logic [15:0] s_time();
    return {s_min_hi, s_min_lo, s_sec_hi, s_sec_lo};
  endfunction

  function automatic vec_t mkVec(input string nm, input logic s, input logic p, input logic c,
                                 input int n, input logic [15:0] t, input logic r);
    vec_t v;
    v.name = nm; v.s = s; v.p = p; v.c = c; v.n = n; v.t = t; v.r = r;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {15'd0, act}, {15'd0, exp});
  endtask

  task automatic checkBoth(input string name, input logic [15:0] t, input logic r);
    checkOutput({name, "/wrap_time"}, w_time(), t);
    checkOutput({name, "/sat_time"}, s_time(), t);
    checkBit({name, "/wrap_running"}, w_running, r);
    checkBit({name, "/sat_running"}, s_running, r);
  endtask

  task automatic pulseCtl(input logic s, input logic p, input logic c);
    @(negedge clk);
    start = s; stop = p; clear = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  // Three cycles high then three low gives the sync chain and edge flop time to settle
  task automatic tickFast();
    @(negedge clk);
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tickFast();
  endtask

  // Raises tick_in and returns #1 after the edge where the increment lands (N+2)
  task automatic ctlOnRise(input logic s, input logic p, input logic c);
    @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = s; stop = p; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic endRise();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.s || v.p || v.c) pulseCtl(v.s, v.p, v.c);
    tickN(v.n);
    checkBoth(v.name, v.t, v.r);
  endtask

  initial begin
    vecs[0]  = mkVec("reset",        0, 0, 0,   0, 16'h0000, 0);
    vecs[1]  = mkVec("idle_ticks",   0, 0, 0,   3, 16'h0000, 0);
    vecs[2]  = mkVec("start",        1, 0, 0,   0, 16'h0000, 1);
    vecs[3]  = mkVec("to_09",        0, 0, 0,   9, 16'h0009, 1);
    vecs[4]  = mkVec("carry_10",     0, 0, 0,   1, 16'h0010, 1);
    vecs[5]  = mkVec("to_59",        0, 0, 0,  49, 16'h0059, 1);
    vecs[6]  = mkVec("carry_min",    0, 0, 0,   1, 16'h0100, 1);
    vecs[7]  = mkVec("stop",         0, 1, 0,   0, 16'h0100, 0);
    vecs[8]  = mkVec("pause_ticks",  0, 0, 0,   4, 16'h0100, 0);
    vecs[9]  = mkVec("stop_pause",   0, 1, 0,   0, 16'h0100, 0);
    vecs[10] = mkVec("resume",       1, 0, 0,   0, 16'h0100, 1);
    vecs[11] = mkVec("to_1059",      0, 0, 0, 599, 16'h1059, 1);
    vecs[12] = mkVec("carry_10min",  0, 0, 0,   1, 16'h1100, 1);
    vecs[13] = mkVec("clear_run",    0, 0, 1,   0, 16'h0000, 0);
    vecs[14] = mkVec("stop_idle",    0, 1, 0,   0, 16'h0000, 0);
    vecs[15] = mkVec("start_two",    1, 0, 0,   2, 16'h0002, 1);
    vecs[16] = mkVec("clear_again",  0, 0, 1,   0, 16'h0000, 0);

    rst = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef SEC_TICK_COUNTER_ALARM_EN
    alarm_time = 16'h0003;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkBit("reset/wrap_pulse", w_sec_pulse, 1'b0);
    checkBit("reset/wrap_ovf", w_ovf, 1'b0);
    checkBit("reset/sat_ovf", s_ovf, 1'b0);
`ifdef SEC_TICK_COUNTER_ALARM_EN
    checkBit("reset/alarm", w_alarm, 1'b0);
`endif

    for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);

    // sec_pulse lands exactly two clocks after tick_in is first sampled high
    pulseCtl(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tick_in = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      checkBit("lat/n1_pulse", w_sec_pulse, 1'b0);
      @(posedge clk); #1;
      checkBit("lat/n2_pulse", w_sec_pulse, 1'b1);
      checkBit("lat/n2_running", w_running, 1'b1);
      @(posedge clk); #1;
      checkBit("lat/n3_pulse", w_sec_pulse, 1'b0);
      @(negedge clk);
      tick_in = 1'b0;
      repeat (95) @(negedge clk);
    end
    checkBoth("five_ticks", 16'h0005, 1);

    tickN(53);
    checkBoth("at_0058", 16'h0058, 1);
    tickN(1);
    checkBoth("at_0059", 16'h0059, 1);
    tickN(1);
    checkBoth("at_0100", 16'h0100, 1);
    tickN(3539);
    checkBoth("at_5959", 16'h5959, 1);

    ctlOnRise(0, 0, 0);
    checkOutput("wrap/time", w_time(), 16'h0000);
    checkBit("wrap/ovf", w_ovf, 1'b1);
    checkBit("wrap/pulse", w_sec_pulse, 1'b1);
    checkBit("wrap/running", w_running, 1'b1);
    checkOutput("sat/time", s_time(), 16'h5959);
    checkBit("sat/ovf", s_ovf, 1'b1);
    checkBit("sat/pulse", s_sec_pulse, 1'b0);
    checkBit("sat/running", s_running, 1'b0);
    @(posedge clk); #1;
    checkBit("wrap/ovf_once", w_ovf, 1'b0);
    checkBit("sat/ovf_once", s_ovf, 1'b0);
    endRise();

    pulseCtl(1, 0, 0);
    checkBit("sat/restart_running", s_running, 1'b1);
    ctlOnRise(0, 0, 0);
    checkOutput("sat2/time", s_time(), 16'h5959);
    checkBit("sat2/ovf", s_ovf, 1'b1);
    checkBit("sat2/pulse", s_sec_pulse, 1'b0);
    checkBit("sat2/running", s_running, 1'b0);
    checkOutput("wrap2/time", w_time(), 16'h0001);
    checkBit("wrap2/ovf", w_ovf, 1'b0);
    @(posedge clk); #1;
    checkBit("sat2/ovf_once", s_ovf, 1'b0);
    endRise();

    pulseCtl(0, 0, 1);
    checkBoth("cleared", 16'h0000, 0);
    pulseCtl(1, 0, 0);
    tickN(7);
    checkBoth("at_0007", 16'h0007, 1);
    ctlOnRise(0, 1, 0);
    checkOutput("stop_rise/time", w_time(), 16'h0007);
    checkBit("stop_rise/running", w_running, 1'b0);
    checkBit("stop_rise/pulse", w_sec_pulse, 1'b0);
    endRise();
    tickN(2);
    checkBoth("stopped_ticks", 16'h0007, 0);
    pulseCtl(1, 0, 0);
    tickN(1);
    checkBoth("resume_0008", 16'h0008, 1);

    tickN(193);
    checkBoth("at_0321", 16'h0321, 1);
    ctlOnRise(1, 0, 1);
    checkOutput("clr_start/time", w_time(), 16'h0000);
    checkBit("clr_start/running", w_running, 1'b0);
    checkBit("clr_start/pulse", w_sec_pulse, 1'b0);
    checkBit("clr_start/sat_pulse", s_sec_pulse, 1'b0);
    endRise();
    checkBoth("clr_start_after", 16'h0000, 0);

`ifdef SEC_TICK_COUNTER_ALARM_EN
    pulseCtl(1, 0, 0);
    checkBit("alarm/after_start", w_alarm, 1'b0);
    tickN(2);
    checkBit("alarm/at_0002", w_alarm, 1'b0);
    @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checkBit("alarm/before_edge", w_alarm, 1'b0);
    @(posedge clk); #1;
    checkBit("alarm/on_edge", w_alarm, 1'b1);
    checkOutput("alarm/time", w_time(), 16'h0003);
    endRise();
    tickN(1);
    checkOutput("alarm/time_0004", w_time(), 16'h0004);
    checkBit("alarm/held", w_alarm, 1'b1);
    pulseCtl(0, 0, 1);
    checkBit("alarm/cleared", w_alarm, 1'b0);
    checkBit("alarm/sat_cleared", s_alarm, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
